dcache: RTL and testbench

DCACHE -- requirements
Module: dcache

---
 rtl/cpu_types_pkg.sv | 47 ++++
 rtl/dcache_if.sv | 36 +++
 rtl/dcache_way.sv | 50 +++++
 rtl/dcache.sv | 227 ++++++++++++++++++++++
 tb/tb_dcache.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared types for the data cache: address split, frame, FSM states.
// Rev    : 1.0
// ============================================================================
package cpu_types_pkg;

  localparam int c_TAG_W  = 26;
  localparam int c_IDX_W  = 3;
  localparam int c_WORD_W = 32;

  typedef struct packed {
    logic [c_TAG_W-1:0] tag;
    logic [c_IDX_W-1:0] idx;
    logic               blkoff;
    logic [1:0]         bytoff;
  } dcachef_t;

  typedef struct packed {
    logic                          valid;
    logic                          dirty;
    logic [c_TAG_W-1:0]            tag;
    logic [1:0][c_WORD_W-1:0]      data;
  } dframe_t;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    WB0  = 4'd1,
    WB1  = 4'd2,
    LD0  = 4'd3,
    LD1  = 4'd4,
    FCHK = 4'd5,
    FWB0 = 4'd6,
    FWB1 = 4'd7,
    DONE = 4'd8
  } dstate_t;

  // Word address of one half of a block, as seen on the memory bus.
  function automatic logic [31:0] blk_addr(input logic [c_TAG_W-1:0] tag,
                                           input logic [c_IDX_W-1:0] idx,
                                           input logic               word);
    return {tag, idx, word, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_if.sv
`default_nettype none
// ============================================================================
// Module : dcache_if
// Brief  : Datapath request and memory bus signals of the data cache.
// Rev    : 1.0
// ============================================================================
interface dcache_if;

  logic        dmemREN;
  logic        dmemWEN;
  logic        datomic;
  logic        halt;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  modport slave (
    input  dmemREN, dmemWEN, datomic, halt, dmemaddr, dmemstore, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output dmemREN, dmemWEN, datomic, halt, dmemaddr, dmemstore, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

endinterface
`default_nettype wire

// File: rtl/dcache_way.sv
`default_nettype none
// ============================================================================
// Module : dcache_way
// Brief  : One way of the data cache: SETS frames, async read, registered write.
// Rev    : 1.0
// ============================================================================
module dcache_way
  import cpu_types_pkg::*;
#(
  parameter int SETS = 8
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [c_IDX_W-1:0] i_ridx,
  output dframe_t            o_frame,
  input  logic               i_wen,
  input  logic [c_IDX_W-1:0] i_widx,
  input  dframe_t            i_wframe
);

  logic [SETS-1:0]            r_valid;
  logic [SETS-1:0]            r_dirty;
  logic [c_TAG_W-1:0]         r_tag  [SETS];
  logic [1:0][c_WORD_W-1:0]   r_data [SETS];

  // Only the state bits are reset; tag and data are qualified by valid.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_wen) begin
      r_valid[i_widx] <= i_wframe.valid;
      r_dirty[i_widx] <= i_wframe.dirty;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_wen) begin
      r_tag[i_widx]  <= i_wframe.tag;
      r_data[i_widx] <= i_wframe.data;
    end
  end

  assign o_frame = '{valid: r_valid[i_ridx],
                     dirty: r_dirty[i_ridx],
                     tag:   r_tag[i_ridx],
                     data:  r_data[i_ridx]};

endmodule
`default_nettype wire

// File: rtl/dcache.sv
`default_nettype none
// ============================================================================
// Module : dcache
// Brief  : 2-way set-associative write-back data cache with LL/SC and flush.
// Rev    : 1.0
// ============================================================================
module dcache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic     CLK,
  input  logic     nRST,
  dcache_if.slave  dcif
);

  dcachef_t            w_addr;
  dstate_t             r_state, w_next;
  logic [3:0]          r_cnt, w_cnt_next;
  logic [SETS-1:0]     r_lru;
  logic                r_vway;
  logic [31:0]         r_fill0;
  logic                r_link_valid;
  logic [29:0]         r_link_addr;

  logic [c_IDX_W-1:0]  w_ridx;
  dframe_t             w_rframe [WAYS];
  logic [WAYS-1:0]     w_hit;
  logic [WAYS-1:0]     w_wen;
  dframe_t             w_wframe;
  logic                w_hway;
  dframe_t             w_hframe, w_vframe, w_iframe, w_fframe;
  logic                w_store, w_load, w_req, w_sc, w_ll;
  logic                w_link_match, w_sc_fail;
  logic                w_lru_we, w_lru_val, w_fill_we, w_link_set, w_link_clr;
  logic                w_unused;

  assign w_addr   = dcachef_t'(dcif.dmemaddr);
  assign w_unused = &{1'b0, w_addr.bytoff};

  // Flush walks frames by counter {index, way}; otherwise index by request.
  assign w_ridx = (r_state == FCHK || r_state == FWB0 || r_state == FWB1)
                ? r_cnt[3:1] : w_addr.idx;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    dcache_way #(.SETS(SETS)) u_way (
      .CLK      (CLK),
      .nRST     (nRST),
      .i_ridx   (w_ridx),
      .o_frame  (w_rframe[g]),
      .i_wen    (w_wen[g]),
      .i_widx   (w_ridx),
      .i_wframe (w_wframe)
    );
    assign w_hit[g] = w_rframe[g].valid && (w_rframe[g].tag == w_addr.tag);
  end

  assign w_hway   = w_hit[1];
  assign w_hframe = w_rframe[w_hway];
  assign w_vframe = w_rframe[r_vway];
  assign w_iframe = w_rframe[r_lru[w_addr.idx]];
  assign w_fframe = w_rframe[r_cnt[0]];

  // Both enables together are treated as a store.
  assign w_store      = dcif.dmemWEN;
  assign w_load       = dcif.dmemREN & ~dcif.dmemWEN;
  assign w_req        = w_store | w_load;
  assign w_sc         = dcif.datomic & w_store;
  assign w_ll         = dcif.datomic & w_load;
  assign w_link_match = r_link_valid && (r_link_addr == dcif.dmemaddr[31:2]);
  assign w_sc_fail    = w_sc & ~w_link_match;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_cnt_next    = r_cnt;
    w_wen         = '0;
    w_wframe      = w_hframe;
    w_lru_we      = 1'b0;
    w_lru_val     = 1'b0;
    w_fill_we     = 1'b0;
    w_link_set    = 1'b0;
    w_link_clr    = 1'b0;
    dcif.dhit     = 1'b0;
    dcif.dmemload = '0;
    dcif.flushed  = 1'b0;
    dcif.dREN     = 1'b0;
    dcif.dWEN     = 1'b0;
    dcif.daddr    = '0;
    dcif.dstore   = '0;

    case (r_state)
      IDLE: begin
        if (dcif.halt) begin
          w_next     = FCHK;
          w_cnt_next = '0;
        end else if (w_req) begin
          if (w_sc_fail) begin
            dcif.dhit = 1'b1;
          end else if (|w_hit) begin
            dcif.dhit = 1'b1;
            w_lru_we  = 1'b1;
            w_lru_val = ~w_hway;
            if (w_store) begin
              w_wen[w_hway]                  = 1'b1;
              w_wframe.dirty                 = 1'b1;
              w_wframe.data[w_addr.blkoff]   = dcif.dmemstore;
              dcif.dmemload                  = {31'd0, w_sc};
              w_link_clr                     = w_link_match;
            end else begin
              dcif.dmemload = w_hframe.data[w_addr.blkoff];
              w_link_set    = w_ll;
            end
          end else begin
            w_next = (w_iframe.valid && w_iframe.dirty) ? WB0 : LD0;
          end
        end
      end
      WB0: begin
        dcif.dWEN   = 1'b1;
        dcif.daddr  = blk_addr(w_vframe.tag, w_addr.idx, 1'b0);
        dcif.dstore = w_vframe.data[0];
        if (!dcif.dwait) w_next = WB1;
      end
      WB1: begin
        dcif.dWEN   = 1'b1;
        dcif.daddr  = blk_addr(w_vframe.tag, w_addr.idx, 1'b1);
        dcif.dstore = w_vframe.data[1];
        if (!dcif.dwait) w_next = LD0;
      end
      LD0: begin
        dcif.dREN  = 1'b1;
        dcif.daddr = blk_addr(w_addr.tag, w_addr.idx, 1'b0);
        if (!dcif.dwait) begin
          w_fill_we = 1'b1;
          w_next    = LD1;
        end
      end
      LD1: begin
        dcif.dREN  = 1'b1;
        dcif.daddr = blk_addr(w_addr.tag, w_addr.idx, 1'b1);
        if (!dcif.dwait) begin
          w_wen[r_vway] = 1'b1;
          w_wframe      = '{valid: 1'b1, dirty: 1'b0, tag: w_addr.tag,
                            data: {dcif.dload, r_fill0}};
          w_lru_we      = 1'b1;
          w_lru_val     = ~r_vway;
          w_next        = IDLE;
        end
      end
      FCHK: begin
        if (w_fframe.dirty) begin
          w_next = FWB0;
        end else if (r_cnt == 4'd15) begin
          w_next = DONE;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      FWB0: begin
        dcif.dWEN   = 1'b1;
        dcif.daddr  = blk_addr(w_fframe.tag, r_cnt[3:1], 1'b0);
        dcif.dstore = w_fframe.data[0];
        if (!dcif.dwait) w_next = FWB1;
      end
      FWB1: begin
        dcif.dWEN   = 1'b1;
        dcif.daddr  = blk_addr(w_fframe.tag, r_cnt[3:1], 1'b1);
        dcif.dstore = w_fframe.data[1];
        if (!dcif.dwait) begin
          // Frame becomes clean; FCHK then sees it clean and advances.
          w_wen[r_cnt[0]] = 1'b1;
          w_wframe        = w_fframe;
          w_wframe.dirty  = 1'b0;
          w_next          = FCHK;
        end
      end
      DONE: begin
        dcif.flushed = 1'b1;
      end
      default: w_next = IDLE;
    endcase

    if (!nRST) begin
      dcif.dhit     = 1'b0;
      dcif.dmemload = '0;
      dcif.flushed  = 1'b0;
      dcif.dREN     = 1'b0;
      dcif.dWEN     = 1'b0;
      dcif.daddr    = '0;
      dcif.dstore   = '0;
    end
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      r_lru        <= '0;
      r_vway       <= 1'b0;
      r_fill0      <= '0;
      r_link_valid <= 1'b0;
      r_link_addr  <= '0;
    end else begin
      // The victim is latched while idle so it stays fixed for the whole miss.
      if (r_state == IDLE) r_vway <= r_lru[w_addr.idx];
      if (w_fill_we) r_fill0 <= dcif.dload;
      if (w_lru_we) r_lru[w_addr.idx] <= w_lru_val;
      if (w_link_clr) begin
        r_link_valid <= 1'b0;
      end else if (w_link_set) begin
        r_link_valid <= 1'b1;
        r_link_addr  <= dcif.dmemaddr[31:2];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache.sv
`default_nettype none
// ============================================================================
// Module : tb_dcache
// Brief  : Self-checking bench for dcache: ideal-memory model plus directed vectors.
// Rev    : 1.0
// ============================================================================
module tb_dcache;

  logic CLK;
  logic nRST;
  dcache_if dcif ();

  dcache #(.SETS(8), .WAYS(2)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .dcif (dcif)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  int          n_chk;
  int          n_fail;
  logic [31:0] bmem [logic [31:0]];  // backing memory behind the cache
  logic [31:0] imem [logic [31:0]];  // what the processor must observe
  txn_t        txq [$];
  logic        link_v;
  logic [29:0] link_a;
  int          stall_left;
  int          ren_cyc;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] rd_b(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rd_i(input logic [31:0] a);
    return imem.exists(a) ? imem[a] : 32'h0;
  endfunction

  // Memory responder and per-cycle checks against the ideal-memory model.
  always @(negedge CLK or negedge nRST) begin
    if (!nRST) begin
      imem       = bmem;
      link_v     = 1'b0;
      stall_left = 0;
      dcif.dwait = 1'b0;
      dcif.dload = '0;
    end else begin
      logic [31:0] a;
      logic        sc_ok;
      a     = {dcif.dmemaddr[31:2], 2'b00};
      sc_ok = 1'b0;
      if ((dcif.dREN || dcif.dWEN) && stall_left > 0) begin
        dcif.dwait = 1'b1;
        stall_left--;
      end else begin
        dcif.dwait = 1'b0;
      end
      dcif.dload = dcif.dREN ? rd_b(dcif.daddr) : 32'h0;

      chk("ren_wen_exclusive", {31'd0, dcif.dREN & dcif.dWEN}, 32'd0);
      if (!dcif.dREN && !dcif.dWEN) chk("daddr_idle", dcif.daddr, 32'd0);
      else                          chk("dhit_while_busy", {31'd0, dcif.dhit}, 32'd0);
      if (!dcif.dmemREN && !dcif.dmemWEN) chk("dhit_no_request", {31'd0, dcif.dhit}, 32'd0);
      if (dcif.flushed) chk("done_quiet", {29'd0, dcif.dhit, dcif.dREN, dcif.dWEN}, 32'd0);
      if (dcif.dREN) ren_cyc++;

      if (dcif.dWEN && !dcif.dwait) begin
        chk("writeback_data", dcif.dstore, rd_i(dcif.daddr));
        bmem[dcif.daddr] = dcif.dstore;
        txq.push_back('{we: 1'b1, addr: dcif.daddr, data: dcif.dstore});
      end
      if (dcif.dREN && !dcif.dwait)
        txq.push_back('{we: 1'b0, addr: dcif.daddr, data: dcif.dload});

      if (dcif.dhit) begin
        if (dcif.dmemWEN) begin
          if (dcif.datomic) begin
            sc_ok = link_v && (link_a == dcif.dmemaddr[31:2]);
            chk("sc_result", dcif.dmemload, {31'd0, sc_ok});
          end
          if (!dcif.datomic || sc_ok) begin
            imem[a] = dcif.dmemstore;
            if (link_v && link_a == dcif.dmemaddr[31:2]) link_v = 1'b0;
          end
        end else begin
          chk("load_data", dcif.dmemload, rd_i(a));
          if (dcif.datomic) begin
            link_v = 1'b1;
            link_a = dcif.dmemaddr[31:2];
          end
        end
      end
    end
  end

  task automatic clear_req();
    dcif.dmemREN   = 1'b0;
    dcif.dmemWEN   = 1'b0;
    dcif.datomic   = 1'b0;
    dcif.dmemaddr  = '0;
    dcif.dmemstore = '0;
  endtask

  task automatic req(input logic ren, input logic wen, input logic at,
                     input logic [31:0] addr, input logic [31:0] data,
                     output logic [31:0] ld, output int cyc);
    logic got;
    got = 1'b0;
    ld  = '0;
    cyc = 0;
    @(posedge CLK); #1;
    dcif.dmemREN   = ren;
    dcif.dmemWEN   = wen;
    dcif.datomic   = at;
    dcif.dmemaddr  = addr;
    dcif.dmemstore = data;
    while (!got && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (dcif.dhit) begin
        got = 1'b1;
        ld  = dcif.dmemload;
      end
    end
    chk("request_completes", {31'd0, got}, 32'd1);
    @(posedge CLK); #1;
    clear_req();
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_flags"},    {28'd0, dcif.dhit, dcif.flushed, dcif.dREN, dcif.dWEN}, 32'd0);
    chk({name, "_daddr"},    dcif.daddr, 32'd0);
    chk({name, "_dstore"},   dcif.dstore, 32'd0);
    chk({name, "_dmemload"}, dcif.dmemload, 32'd0);
  endtask

  task automatic chk_txn(input int i, input logic we, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t = (i < txq.size()) ? txq[i] : '{we: ~we, addr: 32'hFFFF_FFFF, data: 32'hFFFF_FFFF};
    chk("txn_kind", {31'd0, t.we}, {31'd0, we});
    chk("txn_addr", t.addr, addr);
    if (we) chk("txn_data", t.data, data);
  endtask

  initial begin
    logic [31:0] ld;
    int          cyc;
    int          mark;
    int          mism;
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];

    n_chk = 0; n_fail = 0; stall_left = 0; ren_cyc = 0; link_v = 1'b0; link_a = '0;
    CLK = 1'b0; nRST = 1'b0;
    dcif.halt = 1'b0; dcif.dwait = 1'b0; dcif.dload = '0;
    bmem[32'h40]  = 32'h11; bmem[32'h44]  = 32'h22;
    bmem[32'h240] = 32'h33; bmem[32'h440] = 32'h55;
    bmem[32'h80]  = 32'h66; bmem[32'h100] = 32'h88;
    bmem[32'h180] = 32'h77;
    imem = bmem;

    // A failing SC held during reset would otherwise hit combinationally.
    clear_req();
    dcif.dmemWEN = 1'b1; dcif.datomic = 1'b1; dcif.dmemaddr = 32'h80;
    repeat (2) @(posedge CLK);
    #1 check_quiet("reset");
    clear_req();
    @(negedge CLK); #1 nRST = 1'b1;

    // Cold load fills the block; the neighbouring word then hits.
    mark = txq.size();
    req(1, 0, 0, 32'h40, 0, ld, cyc);
    chk("cold_load_value", ld, 32'h11);
    chk("cold_load_txns", txq.size() - mark, 2);
    chk_txn(mark,     1'b0, 32'h40, 0);
    chk_txn(mark + 1, 1'b0, 32'h44, 0);
    mark = txq.size();
    req(1, 0, 0, 32'h44, 0, ld, cyc);
    chk("hit_load_value", ld, 32'h22);
    chk("hit_load_cycles", cyc, 1);
    chk("hit_no_txn", txq.size() - mark, 0);

    // Dirty victim is written back before the refill.
    req(0, 1, 0, 32'h40, 32'hAB, ld, cyc);
    chk("store_hit_cycles", cyc, 1);
    req(1, 0, 0, 32'h240, 0, ld, cyc);
    chk("set_fill_value", ld, 32'h33);
    mark = txq.size();
    req(1, 0, 0, 32'h440, 0, ld, cyc);
    chk("evict_load_value", ld, 32'h55);
    chk_txn(mark,     1'b1, 32'h40,  32'hAB);
    chk_txn(mark + 1, 1'b1, 32'h44,  32'h22);
    chk_txn(mark + 2, 1'b0, 32'h440, 0);

    // LL/SC success, then SC broken by an intervening store.
    req(1, 0, 1, 32'h80, 0, ld, cyc);
    chk("ll_value", ld, 32'h66);
    req(0, 1, 1, 32'h80, 32'd5, ld, cyc);
    chk("sc_success", ld, 32'd1);
    req(1, 0, 0, 32'h80, 0, ld, cyc);
    chk("after_sc_load", ld, 32'd5);
    req(1, 0, 1, 32'h80, 0, ld, cyc);
    req(0, 1, 0, 32'h80, 32'd7, ld, cyc);
    req(0, 1, 1, 32'h80, 32'd9, ld, cyc);
    chk("sc_fail", ld, 32'd0);
    chk("sc_fail_cycles", cyc, 1);
    req(1, 0, 0, 32'h80, 0, ld, cyc);
    chk("after_scfail_load", ld, 32'd7);

    // Memory stalls three cycles on the first fill word.
    stall_left = 3;
    ren_cyc    = 0;
    req(1, 0, 0, 32'h100, 0, ld, cyc);
    chk("stall_load_value", ld, 32'h88);
    chk("stall_ren_cycles", ren_cyc, 5);

    // Reset while fetching the second word of a block.
    @(posedge CLK); #1;
    dcif.dmemREN = 1'b1; dcif.dmemaddr = 32'h180;
    cyc = 0;
    while (cyc < 100 && !(dcif.dREN && dcif.daddr == 32'h184)) begin
      @(negedge CLK);
      cyc++;
    end
    chk("reached_ld1", {31'd0, dcif.dREN}, 32'd1);
    #1 nRST = 1'b0;
    #1 check_quiet("midmiss_reset");
    clear_req();
    @(posedge CLK); #3 nRST = 1'b1;
    mark = txq.size();
    req(1, 0, 0, 32'h180, 0, ld, cyc);
    chk("reload_value", ld, 32'h77);
    chk("reload_misses", txq.size() - mark, 2);
    chk_txn(mark, 1'b0, 32'h180, 0);

    // Two dirty frames, then flush.
    req(0, 1, 0, 32'h0,   32'hA1, ld, cyc);
    req(0, 1, 0, 32'h208, 32'hB2, ld, cyc);
    mark = txq.size();
    @(posedge CLK); #1 dcif.halt = 1'b1;
    cyc = 0;
    while (cyc < 200 && !dcif.flushed) begin
      @(negedge CLK);
      cyc++;
    end
    chk("flushed_set", {31'd0, dcif.flushed}, 32'd1);
    chk("flush_txns", txq.size() - mark, 4);
    exp_a = '{32'h0, 32'h4, 32'h208, 32'h20C};
    exp_d = '{32'hA1, 32'h0, 32'hB2, 32'h0};
    for (int i = 0; i < 4; i++) chk_txn(mark + i, 1'b1, exp_a[i], exp_d[i]);
    mark = txq.size();
    dcif.dmemREN = 1'b1; dcif.dmemaddr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("flushed_hold", {31'd0, dcif.flushed}, 32'd1);
    end
    chk("done_no_txn", txq.size() - mark, 0);
    clear_req();

    mism = 0;
    foreach (imem[k]) if (rd_b(k) !== imem[k]) mism++;
    chk("memory_coherent", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
